// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// in flight, and presents fetched words through a 2-entry queue made of an
// output register (OR) and a skid buffer (SB) so decode can stall without
// losing a response that is already on its way.
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             stall,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_instr
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

   state_t           state_r;
   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] inflight_pc_r;
   logic             if_valid_r;
   logic [WIDTH-1:0] if_pc_r;
   logic [WIDTH-1:0] if_instr_r;
   logic             sb_valid_r;
   logic [WIDTH-1:0] sb_pc_r;
   logic [WIDTH-1:0] sb_instr_r;

   logic             req_s;
   logic             grant_s;
   logic             resp_s;
   logic             consume_s;
   logic             or_free_s;

   // Per-cycle handshake decode; the request is masked while reset is held
   // and while the skid buffer is occupied so at most two words are queued.
   always_comb begin
      req_s     = 1'b0;
      if (rst_n && (state_r == REQ) && !sb_valid_r) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
      grant_s   = req_s & imem_gnt;
      resp_s    = (state_r == WAIT) & imem_rvalid;
      consume_s = if_valid_r & ~stall;
      or_free_s = ~if_valid_r | consume_s;
   end

   // Request FSM and PC: redirect overrides everything, a granted request
   // advances the PC, responses in DROP are swallowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= REQ;
         pc_r          <= RESET_PC;
         inflight_pc_r <= {WIDTH{1'b0}};
      end else if (redirect_valid) begin
         pc_r <= redirect_pc;
         case (state_r)
            REQ:     state_r <= grant_s     ? DROP : REQ;
            WAIT:    state_r <= imem_rvalid ? REQ  : DROP;
            DROP:    state_r <= imem_rvalid ? REQ  : DROP;
            default: state_r <= REQ;
         endcase
      end else begin
         case (state_r)
            REQ: begin
               if (grant_s) begin
                  pc_r          <= pc_r + PC_STEP;
                  inflight_pc_r <= pc_r;
                  state_r       <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state_r <= REQ;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state_r <= REQ;
               end
            end
            default: state_r <= REQ;
         endcase
      end
   end

   // Output register and skid buffer: the skid entry drains first, then a
   // fresh response goes to whichever slot is free; a redirect empties both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_r <= 1'b0;
         if_pc_r    <= {WIDTH{1'b0}};
         if_instr_r <= {WIDTH{1'b0}};
         sb_valid_r <= 1'b0;
         sb_pc_r    <= {WIDTH{1'b0}};
         sb_instr_r <= {WIDTH{1'b0}};
      end else if (redirect_valid) begin
         if_valid_r <= 1'b0;
         sb_valid_r <= 1'b0;
      end else if (sb_valid_r && or_free_s) begin
         if_valid_r <= 1'b1;
         if_pc_r    <= sb_pc_r;
         if_instr_r <= sb_instr_r;
         sb_valid_r <= 1'b0;
      end else if (resp_s && or_free_s) begin
         if_valid_r <= 1'b1;
         if_pc_r    <= inflight_pc_r;
         if_instr_r <= imem_rdata;
      end else if (resp_s) begin
         sb_valid_r <= 1'b1;
         sb_pc_r    <= inflight_pc_r;
         sb_instr_r <= imem_rdata;
      end else if (consume_s) begin
         if_valid_r <= 1'b0;
      end else begin
         if_valid_r <= if_valid_r;
      end
   end

   assign imem_req  = req_s;
   assign imem_addr = pc_r;
   assign if_valid  = if_valid_r;
   assign if_pc     = if_pc_r;
   assign if_instr  = if_instr_r;

endmodule
